// File: rtl/cacheline_adapter_pkg.sv
// Shared types and widths for the cache-line to burst-memory adapter.
package cacheline_adapter_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BURSTS  = LINE_W / BURST_W;
  localparam int CNT_W   = $clog2(BURSTS);
  localparam int OFF_W   = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP,
    GAP
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Serializes one 256-bit cache line into four 64-bit burst beats and back.
//
// state   | meaning
// IDLE    | waiting for dfp_read / dfp_write (write wins)
// RD_REQ  | bmem_read held until bmem_ready
// RD_WAIT | collecting four rvalid beats into the line buffer
// WR      | presenting beats, advancing on bmem_ready
// RESP    | one-cycle dfp_resp, dfp_rdata = line buffer
// GAP     | request inputs ignored while the cache drops its request
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dfp_addr,
  input  logic               dfp_read,
  input  logic               dfp_write,
  input  logic [LINE_W-1:0]  dfp_wdata,
  output logic [LINE_W-1:0]  dfp_rdata,
  output logic               dfp_resp,
  output logic [31:0]        bmem_addr,
  output logic               bmem_read,
  output logic               bmem_write,
  output logic [BURST_W-1:0] bmem_wdata,
  input  logic               bmem_ready,
  input  logic [31:0]        bmem_raddr,
  input  logic [BURST_W-1:0] bmem_rdata,
  input  logic               bmem_rvalid
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);

  adapter_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        req_addr;

  // Return-beat tag and line-offset address bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{bmem_raddr, dfp_addr[OFF_W-1:0]};

  assign req_addr = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (dfp_write) begin
          addr_d  = req_addr;
          line_d  = dfp_wdata;
          cnt_d   = '0;
          state_d = WR;
        end else if (dfp_read) begin
          addr_d  = req_addr;
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          line_d[BURST_W*cnt_q +: BURST_W] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      WR: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so no dfp_* input reaches an output.
  always_comb begin
    dfp_resp   = 1'b0;
    dfp_rdata  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    case (state_q)
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      WR: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[BURST_W*cnt_q +: BURST_W];
      end
      RESP: begin
        dfp_resp  = 1'b1;
        dfp_rdata = line_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: vector table plus hand-written corner sequences.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        dfp_addr;
  logic               dfp_read, dfp_write;
  logic [LINE_W-1:0]  dfp_wdata, dfp_rdata;
  logic               dfp_resp;
  logic [31:0]        bmem_addr, bmem_raddr;
  logic               bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [BURST_W-1:0] bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit               is_rd;
    logic [LINE_W-1:0] line;
  } resp_t;

  typedef struct {
    bit                is_rd;
    logic [31:0]       addr;
    logic [LINE_W-1:0] line;
    logic [7:0]        rdy;
    logic [7:0]        rv;
    logic [31:0]       exp_addr;
  } vec_t;

  resp_t              resp_q[$];
  logic [BURST_W-1:0] beat_q[$];
  vec_t               vecs[6];

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk)
    assert (!(dfp_read && dfp_write)) else $error("illegal simultaneous dfp_read and dfp_write");

  // Every dfp_resp must match an outstanding request; reads also check the line.
  always @(negedge clk) begin
    resp_t r;
    if (dfp_resp) begin
      if (resp_q.size() == 0) chk("stray_resp", dfp_resp, 0);
      else begin
        r = resp_q.pop_front();
        if (r.is_rd) chk("rd_line", dfp_rdata, r.line);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    chk(name, {dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, |dfp_rdata}, '0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [LINE_W-1:0] beats,
                         input logic [7:0] rdy_pat, input logic [7:0] rv_pat,
                         input logic [31:0] exp_addr);
    bit accepted = 0;
    bit got = 0;
    int nbeat = 0;
    int ci = 0;
    int wi = 0;
    int last = -10;
    resp_q.push_back('{1'b1, beats});
    dfp_addr = addr;
    dfp_read = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin
      tick();
      bmem_ready  = 1'b0;
      bmem_rvalid = 1'b0;
      bmem_rdata  = '0;
      if (dfp_resp) begin
        got = 1;
        chk("rd_resp_latency", c, last + 1);
        dfp_read = 1'b0;
      end else if (!accepted) begin
        chk("rd_cmd", {bmem_read, bmem_addr}, {1'b1, exp_addr});
        bmem_ready = rdy_pat[ci % 8];
        ci++;
        accepted = bmem_ready;
        if (!bmem_ready) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        end
      end else if (nbeat < BURSTS) begin
        if (rv_pat[wi % 8]) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = beats[BURST_W*nbeat +: BURST_W];
          nbeat++;
          if (nbeat == BURSTS) last = c;
        end
        wi++;
      end
    end
    chk("rd_done", got, 1);
    dfp_read    = 1'b0;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                          input logic [7:0] rdy_pat, input logic [31:0] exp_addr,
                          input bit keep_req);
    bit got = 0;
    int ci = 0;
    int last = -10;
    resp_q.push_back('{1'b0, line});
    for (int k = 0; k < BURSTS; k++) beat_q.push_back(line[BURST_W*k +: BURST_W]);
    dfp_addr  = addr;
    dfp_wdata = line;
    dfp_write = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin
      tick();
      bmem_ready = 1'b0;
      if (dfp_resp) begin
        got = 1;
        chk("wr_resp_latency", c, last + 1);
        if (!keep_req) dfp_write = 1'b0;
      end else if (beat_q.size() == 0) begin
        chk("wr_extra_beat", bmem_write, 0);
      end else begin
        chk("wr_beat", {bmem_write, bmem_addr, bmem_wdata}, {1'b1, exp_addr, beat_q[0]});
        bmem_ready = rdy_pat[ci % 8];
        ci++;
        if (bmem_ready) begin
          void'(beat_q.pop_front());
          if (beat_q.size() == 0) last = c;
        end
      end
    end
    chk("wr_done", got, 1);
    beat_q.delete();
    bmem_ready = 1'b0;
  endtask

  task automatic post_resp();
    tick();
    chk("gap_quiet", {dfp_resp, bmem_read, bmem_write}, '0);
    tick();
    check_idle("idle_after_resp");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1234, {64'h4444, 64'h3333, 64'h2222, 64'h1111}, 8'hFF, 8'hFF, 32'h0000_1220};
    vecs[1] = '{1'b1, 32'h8000_00FF, {64'hA1A1_0000_0000_0004, 64'hA1A1_0000_0000_0003,
                                      64'hA1A1_0000_0000_0002, 64'hA1A1_0000_0000_0001}, 8'h08, 8'hA5, 32'h8000_00E0};
    vecs[2] = '{1'b0, 32'h4000_0010, {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA}, 8'h2D, 8'h00, 32'h4000_0000};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 8'hFF, 8'h00, 32'hFFFF_FFE0};
    vecs[4] = '{1'b1, 32'h0000_001F, {64'h8000_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7}, 8'hFF, 8'h0F, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h1234_5660, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                      64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000}, 8'h55, 8'h00, 32'h1234_5660};

    rst = 1'b0; dfp_addr = 32'h0000_1234; dfp_read = 1'b1; dfp_write = 1'b0;
    dfp_wdata = '0; bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset held while a read request is pending.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("reset_outputs");
    end
    dfp_read = 1'b0; bmem_ready = 1'b0; rst = 1'b1;
    tick();
    check_idle("idle_post_reset");

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].line, vecs[i].rdy, vecs[i].rv, vecs[i].exp_addr);
      else               do_write(vecs[i].addr, vecs[i].line, vecs[i].rdy, vecs[i].exp_addr, 1'b0);
      post_resp();
    end

    // Back-to-back: write held through resp, read presented during the gap.
    do_write(32'h0000_5000, {64'h44, 64'h33, 64'h22, 64'h11}, 8'hFF, 32'h0000_5000, 1'b1);
    tick();
    chk("b2b_gap", {dfp_resp, bmem_read, bmem_write}, '0);
    dfp_write = 1'b0;
    dfp_addr  = 32'h0000_2008;
    dfp_read  = 1'b1;
    tick();
    check_idle("b2b_idle");
    do_read(32'h0000_2008, {64'hB4, 64'hB3, 64'hB2, 64'hB1}, 8'hFF, 8'hFF, 32'h0000_2000);
    post_resp();

    // Reset mid-read after two beats, then a fresh read.
    dfp_addr = 32'h0000_3000;
    dfp_read = 1'b1;
    tick();
    chk("mid_rst_cmd", bmem_read, 1);
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0; bmem_rvalid = 1'b1; bmem_rdata = 64'hBAD0_0000_0000_0001;
    tick();
    bmem_rdata = 64'hBAD0_0000_0000_0002;
    tick();
    bmem_rvalid = 1'b0; bmem_rdata = '0; dfp_read = 1'b0; rst = 1'b0;
    tick();
    check_idle("mid_rst_idle");
    rst = 1'b1;
    tick();
    check_idle("mid_rst_released");
    do_read(32'h0000_3000, {64'hC4, 64'hC3, 64'hC2, 64'hC1}, 8'hFF, 8'hFF, 32'h0000_3000);
    post_resp();

    chk("scoreboard_empty", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
